// File: rtl/int2float_pipe.sv
// Three-stage elastic integer-to-float encoder with selectable
// rounding, overflow saturation and a saturation event counter.
module int2float_pipe #(
    parameter int IN_W   = 11,
    parameter int MAN_W  = 4,
    parameter int EXP_W  = 3,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man,
    output logic             out_inexact,
    output logic             out_ovf,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_clr
);

    localparam int LW = $clog2(IN_W + 2);
    // Internal exponent is wide enough for the rounding carry and the limit.
    localparam int XW = ((LW > EXP_W) ? LW : EXP_W) + 1;
    localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [IN_W-1:0]  mag1_q, mag1_d;
    logic             sgn1_q, sgn1_d, rnd1_q, rnd1_d;
    logic [XW-1:0]    exp2_q, exp2_d;
    logic [MAN_W-1:0] man2_q, man2_d;
    logic             g2_q, g2_d, st2_q, st2_d;
    logic             sgn2_q, sgn2_d, rnd2_q, rnd2_d;
    logic             sgn3_q, sgn3_d, inx3_q, inx3_d, ovf3_q, ovf3_d;
    logic [EXP_W-1:0] exp3_q, exp3_d;
    logic [MAN_W-1:0] man3_q, man3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic adv3, ld3, adv2, ld2, adv1, in_fire, out_fire;

    assign out_fire = v3_q & out_ready;
    assign adv3     = ~v3_q | out_ready;
    assign ld3      = v2_q & adv3;
    assign adv2     = ~v2_q | adv3;
    assign ld2      = v1_q & adv2;
    assign adv1     = ~v1_q | adv2;
    assign in_fire  = in_valid & adv1;

    assign in_ready    = adv1;
    assign out_valid   = v3_q;
    assign out_sign    = sgn3_q;
    assign out_exp     = exp3_q;
    assign out_man     = man3_q;
    assign out_inexact = inx3_q;
    assign out_ovf     = ovf3_q;
    assign sat_cnt     = cnt_q;

    logic [IN_W-1:0] mag_in;
    logic            sgn_in;
    logic [LW-1:0]   lead;
    logic            big;
    logic [XW-1:0]   sh, sm1;
    logic [IN_W-1:0] gmask, smask;

    always_comb begin
        sgn_in = 1'b0;
        mag_in = in_data;
        if (SIGNED != 0 && in_data[IN_W-1]) begin
            sgn_in = 1'b1;
            mag_in = ~in_data + 1'b1;
        end
        lead = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (mag1_q[i]) lead = LW'(i);
        end
        big   = |(mag1_q >> MAN_W);
        sh    = XW'(lead) - XW'(MAN_W - 1);
        sm1   = sh - XW'(1);
        gmask = {{(IN_W-1){1'b0}}, 1'b1} << sm1;
        smask = gmask - 1'b1;

        v1_d   = in_fire | (v1_q & ~ld2);
        mag1_d = in_fire ? mag_in : mag1_q;
        sgn1_d = in_fire ? sgn_in : sgn1_q;
        rnd1_d = in_fire ? in_rnd : rnd1_q;

        v2_d   = ld2 | (v2_q & ~ld3);
        exp2_d = exp2_q;
        man2_d = man2_q;
        g2_d   = g2_q;
        st2_d  = st2_q;
        sgn2_d = sgn2_q;
        rnd2_d = rnd2_q;
        if (ld2) begin
            exp2_d = big ? sh : '0;
            man2_d = big ? MAN_W'(mag1_q >> sh) : mag1_q[MAN_W-1:0];
            g2_d   = big & |(mag1_q & gmask);
            st2_d  = big & |(mag1_q & smask);
            sgn2_d = sgn1_q;
            rnd2_d = rnd1_q;
        end
    end

    logic             rnd_up, ovf;
    logic [MAN_W:0]   manp;
    logic [XW-1:0]    exp_r;
    logic [MAN_W-1:0] man_r;

    always_comb begin
        rnd_up = rnd2_q & g2_q & (st2_q | man2_q[0]);
        manp   = {1'b0, man2_q} + {{MAN_W{1'b0}}, rnd_up};
        exp_r  = exp2_q + {{(XW-1){1'b0}}, manp[MAN_W]};
        man_r  = manp[MAN_W] ? {1'b1, {(MAN_W-1){1'b0}}}
                             : manp[MAN_W-1:0];
        ovf    = exp_r > EMAX;

        v3_d   = ld3 | (v3_q & ~out_fire);
        sgn3_d = sgn3_q;
        exp3_d = exp3_q;
        man3_d = man3_q;
        inx3_d = inx3_q;
        ovf3_d = ovf3_q;
        if (ld3) begin
            sgn3_d = sgn2_q;
            exp3_d = ovf ? '1 : exp_r[EXP_W-1:0];
            man3_d = ovf ? '1 : man_r;
            inx3_d = g2_q | st2_q | ovf;
            ovf3_d = ovf;
        end

        cnt_d = cnt_q;
        if (sat_clr) begin
            cnt_d = '0;
        end else if (out_fire & ovf3_q & ~&cnt_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            mag1_q <= '0;
            sgn1_q <= 1'b0;
            rnd1_q <= 1'b0;
            exp2_q <= '0;
            man2_q <= '0;
            g2_q   <= 1'b0;
            st2_q  <= 1'b0;
            sgn2_q <= 1'b0;
            rnd2_q <= 1'b0;
            sgn3_q <= 1'b0;
            exp3_q <= '0;
            man3_q <= '0;
            inx3_q <= 1'b0;
            ovf3_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            mag1_q <= mag1_d;
            sgn1_q <= sgn1_d;
            rnd1_q <= rnd1_d;
            exp2_q <= exp2_d;
            man2_q <= man2_d;
            g2_q   <= g2_d;
            st2_q  <= st2_d;
            sgn2_q <= sgn2_d;
            rnd2_q <= rnd2_d;
            sgn3_q <= sgn3_d;
            exp3_q <= exp3_d;
            man3_q <= man3_d;
            inx3_q <= inx3_d;
            ovf3_q <= ovf3_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
